fpa_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational float adder: IEEE-754-style add/subtract of two (1+EXP_SIZE+MANTIS_SIZE)-bit numbers.
- Three registered stages with valid/ready flow control and a per-operation tag.
- Adds features the combinational adder lacks: selectable rounding mode, subtract opcode, exception flags and full subnormal support.
- Sits between the operand scheduler and the result writeback.

---
 rtl/fpa_pipe.sv | 265 ++++++++++++++++++++++++++
 tb/tb_fpa_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fpa_pipe.sv
// fpa_pipe: three-stage pipelined IEEE-754-style adder/subtractor.
//
// Stage 1 unpacks and classifies both operands, applies the subtract opcode,
// orders them by magnitude, aligns the smaller mantissa (keeping guard,
// round and sticky bits) and resolves NaN/Inf/zero-zero cases into a bypass
// result. Stage 2 does the effective add/subtract and normalises. Stage 3
// rounds, packs and raises flags into the output registers.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (number_A, number_B, op_sub,
//                         rnd_mode, tag_in)
//   out_valid / out_ready output handshake (number_out, tag_out, flags)
//   flags                 {invalid, overflow, inexact}
//
// Handshake: a transfer happens on a side when its valid and ready are both
// high at a rising edge. The whole pipe moves together on adv = ~out_valid |
// out_ready; in_ready equals adv. When adv is low every stage holds, so the
// output bundle stays stable until it is taken. Empty slots (bubbles) move
// with the pipe but never raise out_valid.
module fpa_pipe #(
    parameter int EXP_SIZE    = 8,
    parameter int MANTIS_SIZE = 23,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [EXP_SIZE+MANTIS_SIZE:0]     number_A,
    input  logic [EXP_SIZE+MANTIS_SIZE:0]     number_B,
    input  logic                              op_sub,
    input  logic                              rnd_mode,
    input  logic [TAG_WIDTH-1:0]              tag_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [EXP_SIZE+MANTIS_SIZE:0]     number_out,
    output logic [TAG_WIDTH-1:0]              tag_out,
    output logic [2:0]                        flags
);
    localparam int E   = EXP_SIZE;
    localparam int M   = MANTIS_SIZE;
    localparam int W   = 1 + E + M;
    localparam int MW  = M + 4;            // hidden + fraction + G,R,S
    localparam int EW  = E + 1;            // exponent with carry headroom
    localparam int LZW = $clog2(MW + 1);

    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, order, align, resolve specials
    // ------------------------------------------------------------------
    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    logic         nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sa = number_A[W-1];
    assign sb = number_B[W-1] ^ op_sub;
    assign ea = number_A[W-2:M];
    assign eb = number_B[W-2:M];
    assign fa = number_A[M-1:0];
    assign fb = number_B[M-1:0];

    assign nan_a  = (&ea) & (|fa);
    assign nan_b  = (&eb) & (|fb);
    assign inf_a  = (&ea) & ~(|fa);
    assign inf_b  = (&eb) & ~(|fb);
    assign zero_a = ~(|ea) & ~(|fa);
    assign zero_b = ~(|eb) & ~(|fb);

    logic          g_sign;
    logic [E-1:0]  g_exp, s_exp, exp_diff;
    logic [M:0]    g_man, s_man;
    logic [MW-1:0] small_ext, shifted, lost_mask, aligned;
    logic          bypass_d;
    logic [W-1:0]  bypass_val_d;
    logic [2:0]    bypass_flags_d;

    always_comb begin
        // Subnormals behave as exponent 1 with a zero hidden bit.
        if (number_A[W-2:0] >= number_B[W-2:0]) begin
            g_sign = sa;
            g_exp  = (|ea) ? ea : E'(1);
            g_man  = {|ea, fa};
            s_exp  = (|eb) ? eb : E'(1);
            s_man  = {|eb, fb};
        end else begin
            g_sign = sb;
            g_exp  = (|eb) ? eb : E'(1);
            g_man  = {|eb, fb};
            s_exp  = (|ea) ? ea : E'(1);
            s_man  = {|ea, fa};
        end
        exp_diff  = g_exp - s_exp;
        small_ext = {s_man, 3'b000};
        shifted   = '0;
        lost_mask = '0;
        if (int'(exp_diff) >= MW) begin
            // Everything falls below the round bit: only stickiness survives.
            aligned = {{(MW-1){1'b0}}, |s_man};
        end else begin
            shifted   = small_ext >> exp_diff;
            lost_mask = (MW'(1) << exp_diff) - MW'(1);
            aligned   = {shifted[MW-1:1], shifted[0] | (|(small_ext & lost_mask))};
        end

        bypass_d       = 1'b1;
        bypass_val_d   = '0;
        bypass_flags_d = 3'b000;
        if (nan_a | nan_b) begin
            bypass_val_d   = QNAN;
            // A NaN with a clear fraction MSB is signalling.
            bypass_flags_d = {(nan_a & ~fa[M-1]) | (nan_b & ~fb[M-1]), 2'b00};
        end else if (inf_a & inf_b & (sa != sb)) begin
            bypass_val_d   = QNAN;
            bypass_flags_d = 3'b100;
        end else if (inf_a) begin
            bypass_val_d = {sa, {E{1'b1}}, {M{1'b0}}};
        end else if (inf_b) begin
            bypass_val_d = {sb, {E{1'b1}}, {M{1'b0}}};
        end else if (zero_a & zero_b) begin
            // Only (-0)+(-0) keeps the negative sign.
            bypass_val_d = {sa & sb, {(W-1){1'b0}}};
        end else begin
            bypass_d = 1'b0;
        end
    end

    logic                 s1_valid, s1_rnd, s1_sign, s1_eff_sub, s1_bypass;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic [E-1:0]         s1_exp;
    logic [MW-1:0]        s1_man_g, s1_man_s;
    logic [W-1:0]         s1_bypass_val;
    logic [2:0]           s1_bypass_flags;

    // ------------------------------------------------------------------
    // Stage 2: effective add/subtract and normalisation
    // ------------------------------------------------------------------
    logic [MW:0]    sum;
    logic [EW-1:0]  exp_w, limit, sh, exp2_d;
    logic [MW-1:0]  man2_d;
    logic [LZW-1:0] lz;
    logic           sign2_d;

    always_comb begin
        // Operands are ordered by magnitude, so subtraction never borrows.
        if (s1_eff_sub) sum = {1'b0, s1_man_g} - {1'b0, s1_man_s};
        else            sum = {1'b0, s1_man_g} + {1'b0, s1_man_s};
        exp_w = {1'b0, s1_exp};

        lz = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (sum[i]) lz = LZW'(MW - 1 - i);
        end

        limit = exp_w - EW'(1);
        sh    = '0;
        if (sum[MW]) begin
            man2_d = {sum[MW:2], sum[1] | sum[0]};
            exp2_d = exp_w + EW'(1);
        end else begin
            // Never shift the exponent below 1; the result stays subnormal.
            sh     = (EW'(lz) > limit) ? limit : EW'(lz);
            man2_d = sum[MW-1:0] << sh;
            exp2_d = exp_w - sh;
        end
        // Exact cancellation of nonzero operands yields +0.
        sign2_d = (sum == '0) ? 1'b0 : s1_sign;
    end

    logic                 s2_valid, s2_rnd, s2_sign, s2_bypass;
    logic [TAG_WIDTH-1:0] s2_tag;
    logic [EW-1:0]        s2_exp;
    logic [MW-1:0]        s2_man;
    logic [W-1:0]         s2_bypass_val;
    logic [2:0]           s2_bypass_flags;

    // ------------------------------------------------------------------
    // Stage 3: round, pack, flags
    // ------------------------------------------------------------------
    logic          g_bit, r_bit, st_bit, round_up, inexact, hidden;
    logic [M+1:0]  rounded;
    logic [EW-1:0] exp_r;
    logic [M-1:0]  frac_r;
    logic [W-1:0]  result_d;
    logic [2:0]    flags_d;

    always_comb begin
        g_bit    = s2_man[2];
        r_bit    = s2_man[1];
        st_bit   = s2_man[0];
        inexact  = g_bit | r_bit | st_bit;
        round_up = ~s2_rnd & g_bit & (r_bit | st_bit | s2_man[3]);
        rounded  = {1'b0, s2_man[MW-1:3]} + {{(M+1){1'b0}}, round_up};
        if (rounded[M+1]) begin
            exp_r  = s2_exp + EW'(1);
            frac_r = rounded[M:1];
            hidden = 1'b1;
        end else begin
            exp_r  = s2_exp;
            frac_r = rounded[M-1:0];
            hidden = rounded[M];
        end

        if (s2_bypass) begin
            result_d = s2_bypass_val;
            flags_d  = s2_bypass_flags;
        end else if (exp_r >= {1'b0, {E{1'b1}}}) begin
            flags_d = 3'b011;
            if (s2_rnd) result_d = {s2_sign, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
            else        result_d = {s2_sign, {E{1'b1}}, {M{1'b0}}};
        end else begin
            // A clear hidden bit means the value is subnormal (or zero).
            result_d = {s2_sign, hidden ? exp_r[E-1:0] : {E{1'b0}}, frac_r};
            flags_d  = {2'b00, inexact};
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            number_out <= '0;
            tag_out    <= '0;
            flags      <= '0;
        end else if (adv) begin
            s1_valid        <= in_valid;
            s1_tag          <= tag_in;
            s1_rnd          <= rnd_mode;
            s1_sign         <= g_sign;
            s1_eff_sub      <= sa ^ sb;
            s1_exp          <= g_exp;
            s1_man_g        <= {g_man, 3'b000};
            s1_man_s        <= aligned;
            s1_bypass       <= bypass_d;
            s1_bypass_val   <= bypass_val_d;
            s1_bypass_flags <= bypass_flags_d;

            s2_valid        <= s1_valid;
            s2_tag          <= s1_tag;
            s2_rnd          <= s1_rnd;
            s2_sign         <= sign2_d;
            s2_exp          <= exp2_d;
            s2_man          <= man2_d;
            s2_bypass       <= s1_bypass;
            s2_bypass_val   <= s1_bypass_val;
            s2_bypass_flags <= s1_bypass_flags;

            out_valid       <= s2_valid;
            number_out      <= result_d;
            tag_out         <= s2_tag;
            flags           <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpa_pipe.sv
// tb_fpa_pipe: directed bench for fpa_pipe (single precision).
// Covers reset values, nominal add, rounding modes, cancellation, specials,
// overflow, subnormals, backpressure ordering/stability and mid-stream reset.
module tb_fpa_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] number_A;
    logic [31:0] number_B;
    logic        op_sub;
    logic        rnd_mode;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] number_out;
    logic [3:0]  tag_out;
    logic [2:0]  flags;

    int tests = 0;
    int fails = 0;
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    fpa_pipe #(.EXP_SIZE(8), .MANTIS_SIZE(23), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .number_A(number_A), .number_B(number_B),
        .op_sub(op_sub), .rnd_mode(rnd_mode), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .number_out(number_out), .tag_out(tag_out), .flags(flags)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic rnd, input logic [3:0] tag,
                          input logic [31:0] exp_val, input logic [2:0] exp_fl);
        int lat;
        number_A  = a;
        number_B  = b;
        op_sub    = sub;
        rnd_mode  = rnd;
        tag_in    = tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({name, "/in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check({name, "/latency"}, 32'(lat), 32'd3);
        check({name, "/value"}, number_out, exp_val);
        check({name, "/tag"}, 32'(tag_out), 32'(tag));
        check({name, "/flags"}, 32'(flags), 32'(exp_fl));
        step();
    endtask

    logic [31:0] bv[8];
    logic [31:0] ev[8];
    logic [35:0] front;
    logic        stall_prev;
    logic [31:0] prev_num;
    logic [3:0]  prev_tag;
    logic [2:0]  prev_fl;
    int          issued, got, cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        number_A = '0; number_B = '0; op_sub = 1'b0; rnd_mode = 1'b0; tag_in = '0;
        step();
        step();
        rst = 1'b0;
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/number_out", number_out, 32'h0);
        check("reset/tag_out", 32'(tag_out), 32'd0);
        check("reset/flags", 32'(flags), 32'd0);
        check("reset/in_ready", 32'(in_ready), 32'd1);

        run_op("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4'd5, 32'h40400000, 3'b000);
        run_op("rne",       32'h3F800000, 32'h33C00000, 1'b0, 1'b0, 4'd1, 32'h3F800001, 3'b001);
        run_op("rtz",       32'h3F800000, 32'h33C00000, 1'b0, 1'b1, 4'd2, 32'h3F800000, 3'b001);
        run_op("cancel",    32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 4'd3, 32'h00000000, 3'b000);
        run_op("sub_1_2",   32'h3F800000, 32'h40000000, 1'b1, 1'b0, 4'd4, 32'hBF800000, 3'b000);
        run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 4'd6, 32'h7FC00000, 3'b100);
        run_op("ovf_rne",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 4'd7, 32'h7F800000, 3'b011);
        run_op("ovf_rtz",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 4'd8, 32'h7F7FFFFF, 3'b011);
        run_op("sub_add",   32'h00000001, 32'h00000001, 1'b0, 1'b0, 4'd9, 32'h00000002, 3'b000);
        run_op("sub_sub",   32'h00800000, 32'h00000001, 1'b1, 1'b0, 4'd10, 32'h007FFFFF, 3'b000);
        run_op("snan",      32'h7F800001, 32'h3F800000, 1'b0, 1'b0, 4'd11, 32'h7FC00000, 3'b100);
        run_op("qnan",      32'h7FC00001, 32'h3F800000, 1'b0, 1'b0, 4'd12, 32'h7FC00000, 3'b000);
        run_op("ninf_fin",  32'hFF800000, 32'h3F800000, 1'b0, 1'b0, 4'd13, 32'hFF800000, 3'b000);
        run_op("nz_nz",     32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'd14, 32'h80000000, 3'b000);
        run_op("pz_nz",     32'h00000000, 32'h80000000, 1'b0, 1'b0, 4'd15, 32'h00000000, 3'b000);

        // Backpressure: 1.0 + k for k = 1..8, out_ready pattern 1,0,0,1.
        bv[0] = 32'h3F800000; ev[0] = 32'h40000000;
        bv[1] = 32'h40000000; ev[1] = 32'h40400000;
        bv[2] = 32'h40400000; ev[2] = 32'h40800000;
        bv[3] = 32'h40800000; ev[3] = 32'h40A00000;
        bv[4] = 32'h40A00000; ev[4] = 32'h40C00000;
        bv[5] = 32'h40C00000; ev[5] = 32'h40E00000;
        bv[6] = 32'h40E00000; ev[6] = 32'h41000000;
        bv[7] = 32'h41000000; ev[7] = 32'h41100000;
        issued = 0; got = 0; cyc = 0; stall_prev = 1'b0;
        prev_num = '0; prev_tag = '0; prev_fl = '0;
        while (got < 8 && cyc < 80) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (issued < 8) begin
                in_valid = 1'b1;
                number_A = 32'h3F800000;
                number_B = bv[issued];
                op_sub   = 1'b0;
                rnd_mode = 1'b0;
                tag_in   = 4'(issued);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp/in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (stall_prev) begin
                check("bp/hold_valid", 32'(out_valid), 32'd1);
                check("bp/hold_value", number_out, prev_num);
                check("bp/hold_tag", 32'(tag_out), 32'(prev_tag));
                check("bp/hold_flags", 32'(flags), 32'(prev_fl));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp/extra_result", 32'd1, 32'(exp_q.size()));
                end else begin
                    front = exp_q.pop_front();
                    check("bp/tag", 32'(tag_out), 32'(front[35:32]));
                    check("bp/value", number_out, front[31:0]);
                    check("bp/flags", 32'(flags), 32'd0);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({4'(issued), ev[issued]});
                issued++;
            end
            stall_prev = out_valid && !out_ready;
            prev_num   = number_out;
            prev_tag   = tag_out;
            prev_fl    = flags;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp/delivered", 32'(got), 32'd8);
        check("bp/queue_empty", 32'(exp_q.size()), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp/no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with three operations in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            number_A = 32'h3F800000;
            number_B = 32'h3F800000;
            op_sub   = 1'b0;
            rnd_mode = 1'b0;
            tag_in   = 4'(9 + i);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst/no_stale", 32'(out_valid), 32'd0);
        end
        run_op("post_rst", 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4'd6, 32'h40400000, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
